// File: rtl/usb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb_pkg
// Description : Shared USB full-speed types and constants (TX/RX paths).
// Revision    : 1.0 - initial release
// ============================================================================
package usb_pkg;

    typedef enum logic [2:0] {
        TX_NONE  = 3'd0,
        TX_DATA0 = 3'd1,
        TX_ACK   = 3'd2,
        TX_NAK   = 3'd3,
        TX_STALL = 3'd4
    } tx_packet_t;

    localparam logic [3:0] c_PID_DATA0 = 4'h3;
    localparam logic [3:0] c_PID_ACK   = 4'h2;
    localparam logic [3:0] c_PID_NAK   = 4'hA;
    localparam logic [3:0] c_PID_STALL = 4'hE;

    typedef enum logic [1:0] {
        LINE_J   = 2'd0,
        LINE_K   = 2'd1,
        LINE_SE0 = 2'd2
    } line_state_t;

    localparam logic [15:0] c_CRC16_POLY    = 16'h8005;
    localparam logic [15:0] c_CRC16_INIT    = 16'hFFFF;
    localparam logic [15:0] c_CRC16_RESIDUE = 16'hB001;
    localparam logic [7:0]  c_SYNC_BYTE     = 8'h80;

    // Bits travel LSB first, so the serial CRC runs in reflected form.
    function automatic logic [15:0] reflect16(input logic [15:0] value);
        logic [15:0] result;
        for (int i = 0; i < 16; i++) result[i] = value[15-i];
        return result;
    endfunction

    localparam logic [15:0] c_CRC16_POLY_REFL = reflect16(c_CRC16_POLY);

    function automatic logic [7:0] pid_byte(input logic [2:0] code);
        logic [3:0] pid;
        case (code)
            3'd1:    pid = c_PID_DATA0;
            3'd2:    pid = c_PID_ACK;
            3'd3:    pid = c_PID_NAK;
            default: pid = c_PID_STALL;
        endcase
        return {~pid, pid};
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb_crc16.sv
`default_nettype none
// ============================================================================
// Module      : usb_crc16
// Description : Serial USB CRC16, one payload bit per shift_en, LSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_crc16
    import usb_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic        shift_en,
    input  logic        din,
    output logic [15:0] crc_out
);

    logic [15:0] r_crc;
    logic        w_fb;

    assign w_fb = din ^ r_crc[0];

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_crc <= c_CRC16_INIT;
        end else if (clear) begin
            r_crc <= c_CRC16_INIT;
        end else if (shift_en) begin
            r_crc <= (r_crc >> 1) ^ (w_fb ? c_CRC16_POLY_REFL : 16'h0000);
        end
    end

    assign crc_out = r_crc;

endmodule
`default_nettype wire

// File: rtl/usb_tx.sv
`default_nettype none
// ============================================================================
// Module      : usb_tx
// Description : USB FS packet transmitter: SYNC/PID/DATA/CRC16/EOP with NRZI
//               and bit stuffing, payload pulled from the TX data buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_tx
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int MAX_PAYLOAD  = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [2:0] tx_packet,
    input  logic [7:0] tx_packet_data,
    input  logic [6:0] buffer_occupancy,
    output logic       get_tx_packet_data,
    output logic       tx_transfer_active,
    output logic       tx_error,
    output logic       dplus_out,
    output logic       dminus_out
);

    localparam int              CNT_W     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] c_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [6:0]      c_MAX_LEN = 7'(MAX_PAYLOAD);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_PID    = 3'd2,
        ST_DATA   = 3'd3,
        ST_CRC_LO = 3'd4,
        ST_CRC_HI = 3'd5,
        ST_EOP    = 3'd6
    } state_t;

    state_t      r_state,   w_state_nxt;
    logic [CNT_W-1:0] r_bit_cnt, w_cnt_nxt;
    logic [7:0]  r_byte,    w_byte_nxt;
    logic [2:0]  r_bit_idx, w_bit_idx_nxt;
    logic [2:0]  r_ones,    w_ones_nxt;
    logic        r_level,   w_level_nxt;
    line_state_t r_line,    w_line_nxt;
    logic [1:0]  r_eop_cnt, w_eop_nxt;
    logic [6:0]  r_len,     w_len_nxt;
    logic [2:0]  r_pkt,     w_pkt_nxt;
    logic        r_active,  w_active_nxt;
    logic        r_error,   w_error_nxt;

    logic        w_tick, w_accept, w_stuff_due;
    logic        w_pop, w_crc_clear, w_crc_shift;
    logic        w_emit, w_emit_bit, w_load, w_to_eop;
    logic [7:0]  w_load_byte;
    logic [6:0]  w_occ_clamped;
    logic [15:0] w_crc;

    assign w_tick        = (r_bit_cnt == '0);
    assign w_accept      = (tx_packet != TX_NONE) && (tx_packet <= TX_STALL);
    assign w_stuff_due   = (r_ones == 3'd6);
    assign w_occ_clamped = (buffer_occupancy > c_MAX_LEN) ? c_MAX_LEN : buffer_occupancy;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_bit_cnt;
        w_byte_nxt    = r_byte;
        w_bit_idx_nxt = r_bit_idx;
        w_ones_nxt    = r_ones;
        w_level_nxt   = r_level;
        w_line_nxt    = r_line;
        w_eop_nxt     = r_eop_cnt;
        w_len_nxt     = r_len;
        w_pkt_nxt     = r_pkt;
        w_active_nxt  = r_active;
        w_error_nxt   = 1'b0;
        w_pop         = 1'b0;
        w_crc_clear   = 1'b0;
        w_crc_shift   = 1'b0;
        w_emit        = 1'b0;
        w_emit_bit    = 1'b0;
        w_load        = 1'b0;
        w_load_byte   = '0;
        w_to_eop      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt  = ST_SYNC;
                    w_pkt_nxt    = tx_packet;
                    w_len_nxt    = (tx_packet == TX_DATA0) ? w_occ_clamped : 7'd0;
                    w_active_nxt = 1'b1;
                    w_crc_clear  = 1'b1;
                    w_load       = 1'b1;
                    w_load_byte  = c_SYNC_BYTE;
                end
            end
            ST_EOP: begin
                if (!w_tick) begin
                    w_cnt_nxt = r_bit_cnt - CNT_W'(1);
                end else begin
                    w_cnt_nxt = c_RELOAD;
                    case (r_eop_cnt)
                        2'd0: w_eop_nxt = 2'd1;
                        2'd1: begin
                            w_eop_nxt   = 2'd2;
                            w_line_nxt  = LINE_J;
                            w_level_nxt = 1'b1;
                        end
                        default: begin
                            w_eop_nxt    = 2'd0;
                            w_state_nxt  = ST_IDLE;
                            w_active_nxt = 1'b0;
                        end
                    endcase
                end
            end
            default: begin
                // Byte states: a pending stuff bit always wins over the next data bit.
                if (!w_tick) begin
                    w_cnt_nxt = r_bit_cnt - CNT_W'(1);
                end else if (w_stuff_due) begin
                    w_emit     = 1'b1;
                    w_emit_bit = 1'b0;
                end else if (r_bit_idx != 3'd7) begin
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    w_emit        = 1'b1;
                    w_emit_bit    = r_byte[w_bit_idx_nxt];
                    w_crc_shift   = (r_state == ST_DATA);
                end else begin
                    case (r_state)
                        ST_SYNC: begin
                            w_state_nxt = ST_PID;
                            w_load      = 1'b1;
                            w_load_byte = pid_byte(r_pkt);
                        end
                        ST_CRC_LO: begin
                            w_state_nxt = ST_CRC_HI;
                            w_load      = 1'b1;
                            w_load_byte = ~w_crc[15:8];
                        end
                        ST_CRC_HI: w_to_eop = 1'b1;
                        default: begin
                            if (r_pkt != TX_DATA0) begin
                                w_to_eop = 1'b1;
                            end else if (r_len == 7'd0) begin
                                w_state_nxt = ST_CRC_LO;
                                w_load      = 1'b1;
                                w_load_byte = ~w_crc[7:0];
                            end else if (buffer_occupancy == 7'd0) begin
                                w_error_nxt = 1'b1;
                                w_to_eop    = 1'b1;
                            end else begin
                                w_pop       = 1'b1;
                                w_state_nxt = ST_DATA;
                                w_len_nxt   = r_len - 7'd1;
                                w_load      = 1'b1;
                                w_load_byte = tx_packet_data;
                                w_crc_shift = 1'b1;
                            end
                        end
                    endcase
                end
            end
        endcase

        if (w_load) begin
            w_byte_nxt    = w_load_byte;
            w_bit_idx_nxt = 3'd0;
            w_emit        = 1'b1;
            w_emit_bit    = w_load_byte[0];
        end
        // NRZI: a raw 0 toggles the line, a raw 1 holds it.
        if (w_emit) begin
            w_level_nxt = w_emit_bit ? r_level : ~r_level;
            w_line_nxt  = w_level_nxt ? LINE_J : LINE_K;
            w_ones_nxt  = w_emit_bit ? r_ones + 3'd1 : 3'd0;
            w_cnt_nxt   = c_RELOAD;
        end
        if (w_to_eop) begin
            w_state_nxt = ST_EOP;
            w_line_nxt  = LINE_SE0;
            w_eop_nxt   = 2'd0;
            w_ones_nxt  = 3'd0;
            w_cnt_nxt   = c_RELOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= c_RELOAD;
            r_byte    <= '0;
            r_bit_idx <= '0;
            r_ones    <= '0;
            r_level   <= 1'b1;
            r_line    <= LINE_J;
            r_eop_cnt <= '0;
            r_len     <= '0;
            r_pkt     <= '0;
            r_active  <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_cnt_nxt;
            r_byte    <= w_byte_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_ones    <= w_ones_nxt;
            r_level   <= w_level_nxt;
            r_line    <= w_line_nxt;
            r_eop_cnt <= w_eop_nxt;
            r_len     <= w_len_nxt;
            r_pkt     <= w_pkt_nxt;
            r_active  <= w_active_nxt;
            r_error   <= w_error_nxt;
        end
    end

    usb_crc16 u_crc (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (w_crc_clear),
        .shift_en (w_crc_shift),
        .din      (w_emit_bit),
        .crc_out  (w_crc)
    );

    // The buffer advances on the pop edge, so no pop may leak out while in reset.
    assign get_tx_packet_data = w_pop & n_rst;
    assign tx_transfer_active = r_active;
    assign tx_error           = r_error;
    assign dplus_out          = (r_line == LINE_J);
    assign dminus_out         = (r_line == LINE_K);

endmodule
`default_nettype wire

// File: tb/tb_usb_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_tx
// Description : Directed self-checking bench for usb_tx with a buffer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_tx;

    logic       tb_clk = 1'b0;
    logic       n_rst;
    logic [2:0] tx_packet;
    logic [7:0] tx_packet_data;
    logic [6:0] buffer_occupancy;
    logic       get_tx_packet_data;
    logic       tx_transfer_active;
    logic       tx_error;
    logic       dplus_out;
    logic       dminus_out;

    always #5 tb_clk = ~tb_clk;

    usb_tx dut (
        .clk                (tb_clk),
        .n_rst              (n_rst),
        .tx_packet          (tx_packet),
        .tx_packet_data     (tx_packet_data),
        .buffer_occupancy   (buffer_occupancy),
        .get_tx_packet_data (get_tx_packet_data),
        .tx_transfer_active (tx_transfer_active),
        .tx_error           (tx_error),
        .dplus_out          (dplus_out),
        .dminus_out         (dminus_out)
    );

    // Buffer model: head presented combinationally, advances on pop.
    logic [7:0] tb_mem [0:63];
    logic [6:0] head;
    int         model_pops;
    logic       tb_load;
    logic [6:0] tb_load_occ;
    int         tb_empty_after;

    assign tx_packet_data = tb_mem[head[5:0]];

    always @(posedge tb_clk) begin
        if (tb_load) begin
            buffer_occupancy <= tb_load_occ;
            head             <= 7'd0;
            model_pops       <= 0;
        end else if (get_tx_packet_data) begin
            head       <= head + 7'd1;
            model_pops <= model_pops + 1;
            buffer_occupancy <= (model_pops + 1 == tb_empty_after) ? 7'd0 : buffer_occupancy - 7'd1;
        end
    end

    int pop_total = 0;
    int err_total = 0;
    int act_total = 0;

    always @(negedge tb_clk) begin
        if (get_tx_packet_data === 1'b1) pop_total <= pop_total + 1;
        if (tx_error === 1'b1)           err_total <= err_total + 1;
        if (tx_transfer_active === 1'b1) act_total <= act_total + 1;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Decoded line capture
    logic       rx_raw [0:1023];
    int         rx_nraw, rx_nse0, rx_nbytes, rx_stuff_err, rx_partial;
    logic       rx_end_j;
    logic [7:0] rx_bytes [0:127];

    task automatic load_buffer(input logic [6:0] occ, input int empty_after);
        @(negedge tb_clk);
        tb_load_occ    = occ;
        tb_empty_after = empty_after;
        tb_load        = 1'b1;
        @(posedge tb_clk);
        #1 tb_load = 1'b0;
    endtask

    task automatic start(input logic [2:0] code);
        @(negedge tb_clk);
        tx_packet = code;
        @(posedge tb_clk);
        #1;
        check("accept_active", tx_transfer_active, 1'b1);
        tx_packet = 3'd0;
    endtask

    // Sample mid-bit, NRZI decode, then strip stuff bits into bytes.
    task automatic collect();
        logic [1:0] sym, prev;
        logic [7:0] cur;
        logic       done;
        int         ones, nbits;
        rx_nraw = 0; rx_nse0 = 0; rx_nbytes = 0; rx_stuff_err = 0; rx_end_j = 1'b0;
        prev = 2'b10; done = 1'b0; cur = 8'h00;
        repeat (4) @(posedge tb_clk);
        #1;
        for (int k = 0; k < 800 && !done; k++) begin
            sym = {dplus_out, dminus_out};
            if (sym == 2'b00) begin
                rx_nse0++;
            end else if (rx_nse0 > 0) begin
                rx_end_j = (sym == 2'b10);
                done     = 1'b1;
            end else begin
                rx_raw[rx_nraw] = (sym == prev);
                prev = sym;
                rx_nraw++;
            end
            if (!done) begin
                repeat (8) @(posedge tb_clk);
                #1;
            end
        end
        check("eop_seen", done, 1'b1);
        ones = 0; nbits = 0;
        for (int i = 0; i < rx_nraw; i++) begin
            if (ones == 6) begin
                if (rx_raw[i]) rx_stuff_err++;
                ones = 0;
            end else begin
                cur[nbits % 8] = rx_raw[i];
                ones = rx_raw[i] ? ones + 1 : 0;
                nbits++;
                if (nbits % 8 == 0) begin
                    rx_bytes[rx_nbytes] = cur;
                    rx_nbytes++;
                end
            end
        end
        rx_partial = nbits % 8;
        for (int i = 0; i < 20 && tx_transfer_active; i++) begin
            @(posedge tb_clk);
            #1;
        end
        check("active_dropped", tx_transfer_active, 1'b0);
    endtask

    // Non-reflected reference CRC fed in wire order; returns ~remainder.
    function automatic logic [15:0] crc_expect(input int n);
        logic [15:0] r;
        logic        fb;
        r = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 8; j++) begin
                fb = tb_mem[i][j] ^ r[15];
                r  = {r[14:0], 1'b0};
                if (fb) r = r ^ 16'h8005;
            end
        end
        return ~r;
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] o;
        for (int i = 0; i < 8; i++) o[i] = v[7-i];
        return o;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          p0, e0, a0, mism, pops_at;
        logic [15:0] crc;
        logic [8:0]  seg;

        n_rst = 1'b0; tx_packet = 3'd0; tb_load = 1'b0;
        tb_load_occ = 7'd0; tb_empty_after = 1000;
        for (int i = 0; i < 64; i++) tb_mem[i] = 8'h00;
        load_buffer(7'd0, 1000);
        repeat (2) @(posedge tb_clk);
        #1;
        check("rst_dplus",  dplus_out, 1'b1);
        check("rst_dminus", dminus_out, 1'b0);
        check("rst_active", tx_transfer_active, 1'b0);
        check("rst_pop",    get_tx_packet_data, 1'b0);
        check("rst_error",  tx_error, 1'b0);
        n_rst = 1'b1;

        // Unused request code
        @(negedge tb_clk);
        tx_packet = 3'd5;
        repeat (4) @(posedge tb_clk);
        #1;
        check("code5_ignored", tx_transfer_active, 1'b0);
        check("code5_line_j", {dplus_out, dminus_out}, 2'b10);
        tx_packet = 3'd0;
        repeat (3) @(posedge tb_clk);

        // ACK handshake
        p0 = pop_total; e0 = err_total; a0 = act_total;
        start(3'd2);
        collect();
        check("ack_sync",     rx_bytes[0], 8'h80);
        check("ack_pid",      rx_bytes[1], 8'hD2);
        check("ack_nbytes",   rx_nbytes, 2);
        check("ack_partial",  rx_partial, 0);
        check("ack_se0_bits", rx_nse0, 2);
        check("ack_end_j",    rx_end_j, 1'b1);
        check("ack_active_cycles", act_total - a0, 152);
        check("ack_pops",     pop_total - p0, 0);
        check("ack_errors",   err_total - e0, 0);

        // DATA0 zero length
        load_buffer(7'd0, 1000);
        p0 = pop_total; e0 = err_total;
        start(3'd1);
        collect();
        check("z_pid",    rx_bytes[1], 8'hC3);
        check("z_nbytes", rx_nbytes, 4);
        check("z_crc_lo", rx_bytes[2], 8'h00);
        check("z_crc_hi", rx_bytes[3], 8'h00);
        check("z_pops",   pop_total - p0, 0);
        check("z_errors", err_total - e0, 0);

        // DATA0 single byte FF
        tb_mem[0] = 8'hFF;
        load_buffer(7'd1, 1000);
        p0 = pop_total;
        start(3'd1);
        collect();
        crc = crc_expect(1);
        for (int i = 0; i < 9; i++) seg[8-i] = rx_raw[16+i];
        check("ff_pops",      pop_total - p0, 1);
        check("ff_nbytes",    rx_nbytes, 5);
        check("ff_payload",   rx_bytes[2], 8'hFF);
        check("ff_stuffed_raw", seg, 9'b111101111);
        check("ff_crc_lo",    rx_bytes[3], rev8(crc[15:8]));
        check("ff_crc_hi",    rx_bytes[4], rev8(crc[7:0]));
        check("ff_stuff_err", rx_stuff_err, 0);

        // DATA0 with 64 incrementing bytes
        for (int i = 0; i < 64; i++) tb_mem[i] = 8'(i);
        load_buffer(7'd64, 1000);
        p0 = pop_total; e0 = err_total;
        start(3'd1);
        collect();
        crc = crc_expect(64);
        mism = 0;
        for (int i = 0; i < 64; i++) if (rx_bytes[2+i] !== 8'(i)) mism++;
        check("b64_pops",       pop_total - p0, 64);
        check("b64_nbytes",     rx_nbytes, 68);
        check("b64_payload_mismatches", mism, 0);
        check("b64_crc_lo",     rx_bytes[66], rev8(crc[15:8]));
        check("b64_crc_hi",     rx_bytes[67], rev8(crc[7:0]));
        check("b64_buffer_empty", buffer_occupancy, 7'd0);
        check("b64_errors",     err_total - e0, 0);
        check("b64_stuff_err",  rx_stuff_err, 0);

        // Underrun: three bytes promised, buffer runs dry after two
        load_buffer(7'd3, 2);
        p0 = pop_total; e0 = err_total;
        start(3'd1);
        collect();
        check("ur_errors",   err_total - e0, 1);
        check("ur_pops",     pop_total - p0, 2);
        check("ur_nbytes",   rx_nbytes, 4);
        check("ur_byte1",    rx_bytes[3], 8'h01);
        check("ur_se0_bits", rx_nse0, 2);
        check("ur_end_j",    rx_end_j, 1'b1);

        // Reset in the middle of the payload
        load_buffer(7'd64, 1000);
        start(3'd1);
        repeat (320) @(posedge tb_clk);
        @(negedge tb_clk);
        n_rst = 1'b0;
        @(posedge tb_clk);
        #1;
        pops_at = pop_total;
        check("mid_rst_line",   {dplus_out, dminus_out}, 2'b10);
        check("mid_rst_active", tx_transfer_active, 1'b0);
        repeat (3) @(posedge tb_clk);
        #1 n_rst = 1'b1;
        repeat (24) @(posedge tb_clk);
        #1;
        check("mid_rst_no_pops", pop_total - pops_at, 0);
        check("mid_rst_idle_line", {dplus_out, dminus_out}, 2'b10);
        check("mid_rst_idle_active", tx_transfer_active, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
